// File: rtl/baud_tick_gen.sv
// baud_tick_gen: baud-rate timing generator for the UART transceiver.
// Produces single-cycle clock-enable ticks in the sysclk domain instead of
// divided clocks: an oversampling tick, a per-bit baud tick and a mid-bit tick.
//
// Ports:
//   sysclk       - system clock, all logic on its rising edge
//   rst_n        - asynchronous active-low reset
//   enable       - high = counting, low = counters frozen
//   sync         - one-cycle pulse, restarts the bit phase (start-bit edge)
//   div_load     - one-cycle pulse, captures div_in as the next divisor
//   div_in       - new divisor (sample period - 1, in sysclk cycles)
//   sample_tick  - one pulse per oversample period
//   baud_tick    - one pulse per bit period
//   mid_tick     - one pulse at the bit centre
//   sample_idx   - sample position within the bit, 0..OVERSAMPLE-1
//   div_pending  - a loaded divisor is waiting for the next sample boundary
module baud_tick_gen #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = CLK_HZ / (9600 * OVERSAMPLE) - 1,
    parameter int unsigned IDX_W       = $clog2(OVERSAMPLE)
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             sample_tick,
    output logic             baud_tick,
    output logic             mid_tick,
    output logic [IDX_W-1:0] sample_idx,
    output logic             div_pending
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] div_reg, div_reg_d;
    logic [DIV_W-1:0] div_nxt, div_nxt_d;
    logic [IDX_W-1:0] idx_d, idx_inc;
    logic             pend_d, sample_d, baud_d, mid_d;

    assign idx_inc = IDX_W'(sample_idx + 1'b1);

    // Next-state logic: sync restarts the phase; otherwise count, with divisor
    // changes deferred to a sample boundary so a period is never cut short.
    always_comb begin
        cnt_d     = cnt;
        idx_d     = sample_idx;
        div_reg_d = div_reg;
        div_nxt_d = div_nxt;
        pend_d    = div_pending;
        sample_d  = 1'b0;
        baud_d    = 1'b0;
        mid_d     = 1'b0;

        if (sync) begin
            cnt_d = '0;
            idx_d = '0;
            if (div_load) begin
                div_reg_d = div_in;
                div_nxt_d = div_in;
                pend_d    = 1'b0;
            end else if (div_pending) begin
                div_reg_d = div_nxt;
                pend_d    = 1'b0;
            end
        end else begin
            if (enable) begin
                if (cnt == div_reg) begin
                    cnt_d    = '0;
                    idx_d    = idx_inc;
                    sample_d = 1'b1;
                    baud_d   = (sample_idx == IDX_LAST);
                    mid_d    = (idx_inc == IDX_MID);
                    if (div_pending) begin
                        div_reg_d = div_nxt;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = DIV_W'(cnt + 1'b1);
                end
            end
            // A load in the same cycle as a boundary stays pending until the next one.
            if (div_load) begin
                div_nxt_d = div_in;
                if (enable) begin
                    pend_d = 1'b1;
                end else begin
                    div_reg_d = div_in;
                    pend_d    = 1'b0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div_reg     <= DIV_RST;
            div_nxt     <= DIV_RST;
            sample_idx  <= '0;
            div_pending <= 1'b0;
            sample_tick <= 1'b0;
            baud_tick   <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            div_reg     <= div_reg_d;
            div_nxt     <= div_nxt_d;
            sample_idx  <= idx_d;
            div_pending <= pend_d;
            sample_tick <= sample_d;
            baud_tick   <= baud_d;
            mid_tick    <= mid_d;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed testbench for baud_tick_gen with OVERSAMPLE=4, DEFAULT_DIV=3.
module tb_baud_tick_gen;

    localparam int unsigned OS    = 4;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned IDX_W = 2;

    logic             sysclk;
    logic             rst_n;
    logic             enable;
    logic             sync;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
    logic             sample_tick;
    logic             baud_tick;
    logic             mid_tick;
    logic [IDX_W-1:0] sample_idx;
    logic             div_pending;

    int checks = 0;
    int errors = 0;

    baud_tick_gen #(
        .CLK_HZ     (100_000_000),
        .OVERSAMPLE (OS),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(3)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync       (sync),
        .div_load   (div_load),
        .div_in     (div_in),
        .sample_tick(sample_tick),
        .baud_tick  (baud_tick),
        .mid_tick   (mid_tick),
        .sample_idx (sample_idx),
        .div_pending(div_pending)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit s, input bit m, input bit b,
                             input int idx, input bit p);
        check_eq({tag, ".sample"}, 32'(sample_tick), 32'(s));
        check_eq({tag, ".mid"},    32'(mid_tick),    32'(m));
        check_eq({tag, ".baud"},   32'(baud_tick),   32'(b));
        check_eq({tag, ".idx"},    32'(sample_idx),  32'(idx));
        check_eq({tag, ".pend"},   32'(div_pending), 32'(p));
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        sync     = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        repeat (3) step();
        check_out("reset", 0, 0, 0, 0, 0);

        // Free run from reset release, edge 1 is the first edge after release.
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            check_out($sformatf("run.e%0d", n), (n % 4) == 0, (n % 16) == 8,
                      (n % 16) == 0, (n / 4) % 4, 0);
        end
        // cnt=0, idx=2 here

        // sync at idx=2, cnt=2
        step(); step();
        check_out("presync", 0, 0, 0, 2, 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_out("sync.s", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("sync.s+%0d", k), (k % 4) == 0, k == 8, 0, k / 4, 0);
        end
        // cnt=0, idx=2

        // enable low at cnt=2
        step(); step();
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_out($sformatf("dis.%0d", k), 0, 0, 0, 2, 0);
        end
        enable = 1'b1;
        step();
        check_out("reen.1", 0, 0, 0, 2, 0);
        step();
        check_out("reen.2", 1, 0, 0, 3, 0);
        // cnt=0, idx=3

        // div_load div_in=1 while cnt=1
        step();
        div_load = 1'b1;
        div_in   = 16'd1;
        step();
        div_load = 1'b0;
        check_out("load.e", 0, 0, 0, 3, 1);
        step();
        check_out("load.e+1", 0, 0, 0, 3, 1);
        step();
        check_out("load.e+2", 1, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("div1.%0d", k), (k % 2) == 0, k == 4, k == 8, (k / 2) % 4, 0);
        end

        // simultaneous sync + div_load with div_in=0
        step();
        sync     = 1'b1;
        div_load = 1'b1;
        div_in   = 16'd0;
        step();
        sync     = 1'b0;
        div_load = 1'b0;
        check_out("sl.s", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("div0.%0d", k), 1, (k % 4) == 2, (k % 4) == 0, k % 4, 0);
        end

        // reset pulse mid-bit: outputs must drop without a clock edge
        step();
        check_out("prerst", 1, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("asyncrst", 0, 0, 0, 0, 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check_out($sformatf("post.e%0d", n), (n % 4) == 0, n == 8, 0, n / 4, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
